// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer, full/almost-full/level flags and sticky overflow for a dual-clock FIFO.
module bin2gray #(
  parameter int W = 5
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

module wptr_full_ctrl #(
  parameter int ADDRSIZE  = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                err_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);
  localparam int A = ADDRSIZE;
  localparam logic [A:0] AF_TH = (A+1)'((2**A) - AF_MARGIN);
  logic [A:0] wbin, wbinnext, wgraynext, rbin, lvlnext, full_ptr;
  assign wen      = winc & ~wfull;
  assign waddr    = wbin[A-1:0];
  assign wbinnext = wbin + {{A{1'b0}}, wen};
  bin2gray #(.W(A+1)) u_b2g (.bin(wbinnext), .gray(wgraynext));
  // Each binary bit is the XOR of all Gray bits from the MSB down to it
  for (genvar g = 0; g <= A; g++) begin : g_g2b
    assign rbin[g] = ^wq2_rptr[A:g];
  end
  assign lvlnext  = wbinnext - rbin;
  assign full_ptr = {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      walmost   <= 1'b0;
      wlevel    <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbinnext;
      wptr      <= wgraynext;
      wfull     <= wgraynext == full_ptr;
      wlevel    <= lvlnext;
      walmost   <= lvlnext >= AF_TH;
      woverflow <= (winc & wfull) | (woverflow & ~err_clr);
    end
endmodule
